cnn_result_tx_ctrl: RTL and testbench
=====================================

Name: cnn_result_tx_ctrl

Overview:
Output scheduler between the CNN fully-connected stage and the byte-wide UART transmitter. On each inference completion it:
- latches the 10 FC scores;
- finds the winning class iteratively and drives the one-hot LED vector;
- sequences a framed, checksummed packet onto the transmitter through a valid/ready handshake.

It owns the top-level state[2:0] and done signals.

Parameters:
CLASSIFICATIONS, 10, number of classes/scores
FC_RESULT_DEPTH, 30, width of each signed FC score
HEADER_BYTE, 8'hA5, packet start marker
BYTES_PER_SCORE, 4, bytes per score on the wire; must equal ceil(FC_RESULT_DEPTH/8)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
cnn_done  in  1  level from CNN core; rising edge means fc_result is valid
fc_result  in  CLASSIFICATIONS*FC_RESULT_DEPTH  flat signed scores; class k occupies bits [k*D +: D]
tx_ready  in  1  byte transmitter can accept a byte
tx_valid  out  1  tx_data is valid
tx_data  out  8  byte to transmit
led  out  CLASSIFICATIONS  one-hot winning class
state  out  3  current FSM state encoding
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the checksum byte is accepted
overrun  out  1  sticky; set by a cnn_done rising edge while busy

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, state=IDLE, score buffer 0, edge-detect register 0.
- Edge detect: cnn_done is registered once; start = cnn_done & ~cnn_done_q.
- FSM encodings:
  - IDLE=0: start -> CAPTURE.
  - CAPTURE=1: latch fc_result into the internal buffer; checksum := HEADER_BYTE; -> ARGMAX.
  - ARGMAX=2: one class compared per cycle, k=1..CLASSIFICATIONS-1; best starts at class 0.
    - Comparison is signed; a strictly greater score replaces best, so ties keep the lowest index.
    - After CLASSIFICATIONS-1 cycles: led := one-hot(best); -> HDR.
  - HDR=3: tx_data=HEADER_BYTE.
  - CLASS=4: tx_data={4'b0, best index}.
  - SCORE=5: scores sent class 0..9, each little-endian, BYTES_PER_SCORE bytes, sign-extended to 32 bits.
  - CSUM=6: tx_data = XOR of every previously sent byte, header included.
  - DONE=7: done=1 for exactly this cycle; -> IDLE.
- Handshake, for all send states:
  - tx_valid=1 and tx_data is stable until the cycle where tx_valid&tx_ready.
  - On that edge the byte is accepted and the checksum is updated: csum ^= tx_data.
  - Then either the byte counter advances or the FSM moves to the next state.
  - tx_ready may be high continuously: one byte per cycle, no bubbles between states.
  - tx_valid=0 in IDLE, CAPTURE, ARGMAX and DONE.
- Packet length: 2 + CLASSIFICATIONS*BYTES_PER_SCORE + 1 = 43 bytes.
- Latency: start edge to first tx_valid = 1 (CAPTURE) + 9 (ARGMAX) = 10 cycles. With tx_ready always high, done is asserted 43 cycles after HDR is entered.
- Boundary conditions:
  - led holds its value through IDLE until the next ARGMAX completion.
  - Scores change on fc_result after CAPTURE have no effect on the packet in flight.
  - A start edge while busy is ignored and sets overrun. overrun clears only on reset.
  - cnn_done held high does not retrigger; a new rising edge is required.
  - A start edge coinciding with DONE is treated as busy (overrun); IDLE is entered the next cycle.
  - tx_ready deasserted mid-packet: hold state, counters and byte indefinitely.
  - Reset mid-packet: immediate abort, tx_valid=0, no partial resume.

Decomposition:
- Shared package cnn_pkg: CLASSIFICATIONS, FC_RESULT_DEPTH, HEADER_BYTE, BYTES_PER_SCORE, and the state encodings IDLE..DONE (3-bit).
- One sub-module, cnn_argmax_seq: iterative signed argmax.
  - Ports: clk, rst, start, scores, valid, index[3:0].
  - Instantiated once; the FSM waits on its valid.
- Byte and score selection stays inline as a mux indexed by the score and byte counters.

Test Plan:
1. Reset while a packet is in flight (tx_ready toggling) -> tx_valid=0, led=0, state=0, busy=0 immediately, without waiting for a clock edge.
2. Scores class k = k*100, cnn_done edge, tx_ready=1 -> led=10'b10_0000_0000.
   - Bytes: A5, 09, then 00 00 00 00, 64 00 00 00, ..., 84 03 00 00, then the XOR checksum.
   - 43 bytes total; done is a single pulse.
3. All scores negative, class 3 = -1 (30'h3FFFFFFF), others -1000 -> led=10'b00_0000_1000; class 3 bytes = FF FF FF FF (sign extension).
4. Tie: classes 2 and 7 both = 500, the rest 0 -> index byte 02, led bit 2 set.
5. tx_ready random 30% duty -> byte sequence identical to scenario 2; tx_data never changes while tx_valid&~tx_ready.
6. Second cnn_done edge during SCORE -> overrun=1, packet unaltered. Next edge after done -> new packet sent, overrun still 1.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared sizes, packet constants and controller state encodings
package cnn_pkg;
   localparam int CLASSIFICATIONS = 10;
   localparam int FC_RESULT_DEPTH = 30;
   localparam int BYTES_PER_SCORE = 4;
   localparam logic [7:0] HEADER_BYTE = 8'hA5;
   typedef enum logic [2:0] {IDLE, CAPTURE, ARGMAX, HDR, CLASS, SCORE, CSUM, DONE} state_t;
endpackage

// File: rtl/cnn_argmax_seq.sv
// cnn_argmax_seq: iterative signed argmax, one class per cycle, ties keep the lowest index
module cnn_argmax_seq import cnn_pkg::*; (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       start,
   input  logic [CLASSIFICATIONS*FC_RESULT_DEPTH-1:0] scores,
   output logic                                       valid,
   output logic [3:0]                                 index
);
   logic [3:0] k, best;
   logic       run;
   logic signed [FC_RESULT_DEPTH-1:0] sk, sb;
   assign sk = scores[k*FC_RESULT_DEPTH +: FC_RESULT_DEPTH];
   assign sb = scores[best*FC_RESULT_DEPTH +: FC_RESULT_DEPTH];
   // index already folds in the current comparison so the final winner is visible with valid
   assign index = (run && sk > sb) ? k : best;
   assign valid = run && k == 4'(CLASSIFICATIONS-1);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k <= '0;
         best <= '0;
         run <= 1'b0;
      end else if (start) begin
         k <= 4'd1;
         best <= '0;
         run <= 1'b1;
      end else if (run) begin
         best <= index;
         k <= k + 4'd1;
         if (valid) run <= 1'b0;
      end
   end
endmodule

// File: rtl/cnn_result_tx_ctrl.sv
// cnn_result_tx_ctrl: latches FC scores, picks the winning class and streams
// a header/class/scores/checksum packet over a valid/ready byte interface
module cnn_result_tx_ctrl import cnn_pkg::*; (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       cnn_done,
   input  logic [CLASSIFICATIONS*FC_RESULT_DEPTH-1:0] fc_result,
   input  logic                                       tx_ready,
   output logic                                       tx_valid,
   output logic [7:0]                                 tx_data,
   output logic [CLASSIFICATIONS-1:0]                 led,
   output logic [2:0]                                 state,
   output logic                                       busy,
   output logic                                       done,
   output logic                                       overrun
);
   localparam int D = FC_RESULT_DEPTH;
   state_t st;
   logic [CLASSIFICATIONS*D-1:0] score_buf;
   logic cnn_done_q, start, acc, am_valid;
   logic [7:0] csum;
   logic [3:0] best, sidx, am_index;
   logic [1:0] bidx;
   logic [D-1:0] cur;
   logic [31:0] ext;
   assign start = cnn_done & ~cnn_done_q;
   assign state = st;
   assign busy = st != IDLE;
   assign tx_valid = st inside {HDR, CLASS, SCORE, CSUM};
   assign acc = tx_valid & tx_ready;
   assign cur = score_buf[sidx*D +: D];
   assign ext = {{(32-D){cur[D-1]}}, cur};
   assign tx_data = st == HDR   ? HEADER_BYTE :
                    st == CLASS ? {4'b0, best} :
                    st == SCORE ? ext[bidx*8 +: 8] :
                    st == CSUM  ? csum : 8'h00;
   cnn_argmax_seq u_argmax (
      .clk(clk), .rst(rst), .start(st == CAPTURE), .scores(score_buf),
      .valid(am_valid), .index(am_index)
   );
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st <= IDLE;
         score_buf <= '0;
         cnn_done_q <= 1'b0;
         csum <= '0;
         best <= '0;
         sidx <= '0;
         bidx <= '0;
         led <= '0;
         done <= 1'b0;
         overrun <= 1'b0;
      end else begin
         cnn_done_q <= cnn_done;
         done <= 1'b0;
         if (start && st != IDLE) overrun <= 1'b1;
         case (st)
            IDLE: if (start) st <= CAPTURE;
            CAPTURE: begin
               score_buf <= fc_result;
               // seeding with the header stands in for accumulating it when HDR is accepted
               csum <= HEADER_BYTE;
               sidx <= '0;
               bidx <= '0;
               st <= ARGMAX;
            end
            ARGMAX: if (am_valid) begin
               best <= am_index;
               led <= {{(CLASSIFICATIONS-1){1'b0}}, 1'b1} << am_index;
               st <= HDR;
            end
            HDR: if (acc) st <= CLASS;
            CLASS: if (acc) begin
               csum <= csum ^ tx_data;
               st <= SCORE;
            end
            SCORE: if (acc) begin
               csum <= csum ^ tx_data;
               if (bidx == 2'(BYTES_PER_SCORE-1)) begin
                  bidx <= '0;
                  if (sidx == 4'(CLASSIFICATIONS-1)) st <= CSUM;
                  else sidx <= sidx + 4'd1;
               end else bidx <= bidx + 2'd1;
            end
            CSUM: if (acc) begin
               done <= 1'b1;
               st <= DONE;
            end
            DONE: st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cnn_result_tx_ctrl.sv
// tb_cnn_result_tx_ctrl: directed self-checking bench for the result packet controller
module tb_cnn_result_tx_ctrl;
   import cnn_pkg::*;
   localparam int N = CLASSIFICATIONS, D = FC_RESULT_DEPTH;
   logic clk = 0, rst = 0, cnn_done = 0, tx_ready = 0;
   logic [N*D-1:0] fc_result = '0;
   logic tx_valid, busy, done, overrun;
   logic [7:0] tx_data;
   logic [N-1:0] led;
   logic [2:0] state;
   int errors = 0, checks = 0;
   logic [7:0] rx[$], ex[$], s2[$];
   int first_v, done_at, done_cnt, stab_bad, nbad, nvalid;

   always #5 clk = ~clk;

   cnn_result_tx_ctrl dut (
      .clk(clk), .rst(rst), .cnn_done(cnn_done), .fc_result(fc_result), .tx_ready(tx_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .led(led), .state(state), .busy(busy),
      .done(done), .overrun(overrun)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_score(input int k, input int v);
      fc_result[k*D +: D] = v[D-1:0];
   endtask

   task automatic set_ramp();
      for (int k = 0; k < N; k++) set_score(k, k*100);
   endtask

   task automatic set_tie();
      for (int k = 0; k < N; k++) set_score(k, 0);
      set_score(2, 500);
      set_score(7, 500);
   endtask

   // expected packet built from the scores currently on fc_result and a hand-picked winner
   task automatic build_exp(input logic [3:0] win);
      logic [31:0] e;
      logic [7:0] c;
      ex.delete();
      ex.push_back(8'hA5);
      ex.push_back({4'h0, win});
      for (int k = 0; k < N; k++) begin
         e = {{(32-D){fc_result[k*D+D-1]}}, fc_result[k*D +: D]};
         for (int b = 0; b < 4; b++) ex.push_back(e[b*8 +: 8]);
      end
      c = 8'h00;
      foreach (ex[i]) c ^= ex[i];
      ex.push_back(c);
   endtask

   task automatic cmp_pkt(input string tag);
      chk({tag, " length"}, rx.size(), 43);
      nbad = 0;
      for (int i = 0; i < 43; i++) if (i >= rx.size() || rx[i] !== ex[i]) nbad++;
      chk({tag, " mismatching bytes"}, nbad, 0);
   endtask

   task automatic do_packet(input bit rnd, input bit hold, input bit mid);
      bit pv = 0, pr = 0;
      logic [7:0] pd = 0;
      int mid_cyc = 0;
      rx.delete();
      first_v = -1; done_at = -1; done_cnt = 0; stab_bad = 0;
      @(negedge clk) cnn_done = 1;
      for (int cyc = 1; cyc < 2000; cyc++) begin
         @(negedge clk);
         tx_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
         if (!hold && cyc == 3) cnn_done = 0;
         if (mid && mid_cyc == 0 && rx.size() >= 20) begin
            cnn_done = 1;
            set_tie();
            mid_cyc = cyc;
         end
         if (mid_cyc != 0 && cyc == mid_cyc + 1) cnn_done = 0;
         if (pv && !pr && (tx_valid !== 1'b1 || tx_data !== pd)) stab_bad++;
         if (tx_valid && first_v < 0) first_v = cyc;
         if (tx_valid && tx_ready) rx.push_back(tx_data);
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = cyc;
         end
         pv = tx_valid; pr = tx_ready; pd = tx_data;
         if (done_at >= 0 && cyc >= done_at + 2) break;
      end
      tx_ready = 0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset tx_valid", tx_valid, 0);
      chk("reset tx_data", tx_data, 0);
      chk("reset led", led, 0);
      chk("reset state", state, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset overrun", overrun, 0);
      rst = 1;
      @(negedge clk);

      set_ramp();
      build_exp(4'd9);
      do_packet(0, 0, 0);
      chk("ramp first valid cycle", first_v, 11);
      chk("ramp done cycle", done_at, 54);
      chk("ramp done pulses", done_cnt, 1);
      cmp_pkt("ramp");
      chk("ramp led", led, 10'h200);
      chk("ramp class byte", rx[1], 8'h09);
      chk("ramp score9 byte0", rx[38], 8'h84);
      chk("ramp score9 byte1", rx[39], 8'h03);
      chk("ramp checksum", rx[42], 8'h09);
      chk("ramp overrun", overrun, 0);
      s2 = rx;
      repeat (5) @(negedge clk);
      chk("led held in idle", led, 10'h200);
      chk("idle after packet", state, 0);

      for (int k = 0; k < N; k++) set_score(k, -1000);
      set_score(3, -1);
      build_exp(4'd3);
      do_packet(0, 0, 0);
      cmp_pkt("negative");
      chk("negative led", led, 10'h008);
      chk("negative class byte", rx[1], 8'h03);
      chk("negative score0 byte0", rx[2], 8'h18);
      chk("negative score0 byte3", rx[5], 8'hFF);
      chk("negative score3 byte0", rx[14], 8'hFF);
      chk("negative score3 byte3", rx[17], 8'hFF);

      set_tie();
      build_exp(4'd2);
      do_packet(0, 1, 0);
      cmp_pkt("tie");
      chk("tie class byte", rx[1], 8'h02);
      chk("tie led", led, 10'h004);
      repeat (20) @(negedge clk);
      chk("held cnn_done no retrigger", state, 0);
      cnn_done = 0;
      @(negedge clk);

      set_ramp();
      build_exp(4'd9);
      do_packet(1, 0, 0);
      cmp_pkt("slow ready");
      nbad = 0;
      for (int i = 0; i < 43; i++) if (i >= rx.size() || rx[i] !== s2[i]) nbad++;
      chk("slow ready vs ramp bytes", nbad, 0);
      chk("slow ready data stable", stab_bad, 0);
      chk("slow ready done pulses", done_cnt, 1);

      build_exp(4'd9);
      do_packet(0, 0, 1);
      cmp_pkt("overrun packet");
      chk("overrun set", overrun, 1);
      chk("overrun edge ignored", state, 0);
      build_exp(4'd2);
      do_packet(0, 0, 0);
      cmp_pkt("after overrun");
      chk("after overrun class byte", rx[1], 8'h02);
      chk("overrun sticky", overrun, 1);

      @(negedge clk) cnn_done = 1;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         @(negedge clk);
         tx_ready = cyc[0];
         if (cyc == 2) cnn_done = 0;
      end
      chk("in flight before reset", busy, 1);
      @(posedge clk);
      #2 rst = 0;
      #1;
      chk("async reset tx_valid", tx_valid, 0);
      chk("async reset led", led, 0);
      chk("async reset state", state, 0);
      chk("async reset busy", busy, 0);
      chk("async reset overrun", overrun, 0);
      @(negedge clk);
      rst = 1;
      tx_ready = 1;
      nvalid = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx_valid) nvalid++;
      end
      chk("no resume after reset", nvalid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
